// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// Latches the granted payload, waits for mem_ack or a timeout, then pulses done (and err on abort).
module mem_port_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_done,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   input  logic [3:0]            d_be,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  d_done,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_be,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  err,
   output logic                  stall
);
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, IF_ACC, D_ACC, RESP} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  last_data_q, last_data_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]            mem_be_q, mem_be_d;
   logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
   logic                  if_done_q, if_done_d;
   logic                  d_done_q, d_done_d;
   logic                  err_q, err_d;
   logic                  grant_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         last_data_q <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_done_q   <= 1'b0;
         d_done_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_data_q <= last_data_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         if_done_q   <= if_done_d;
         d_done_q    <= d_done_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_data_d = last_data_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      if_done_d   = 1'b0;
      d_done_d    = 1'b0;
      err_d       = 1'b0;
      // On a tie, data wins unless data was the previous grant.
      grant_data  = d_req & (~if_req | ~last_data_q);

      case (state_q)
         IDLE: begin
            if (if_req | d_req) begin
               mem_req_d   = 1'b1;
               cnt_d       = '0;
               last_data_d = grant_data;
               if (grant_data) begin
                  mem_we_d    = d_we;
                  mem_addr_d  = d_addr;
                  mem_wdata_d = d_wdata;
                  mem_be_d    = d_be;
                  state_d     = D_ACC;
               end else begin
                  mem_we_d   = 1'b0;
                  mem_addr_d = if_addr;
                  mem_be_d   = 4'b1111;
                  state_d    = IF_ACC;
               end
            end
         end
         IF_ACC, D_ACC: begin
            if (mem_ack || cnt_q == CNT_LAST) begin
               mem_req_d = 1'b0;
               err_d     = ~mem_ack;
               state_d   = RESP;
               if (state_q == IF_ACC) begin
                  if_done_d = 1'b1;
                  if (mem_ack) if_rdata_d = mem_rdata;
               end else begin
                  d_done_d = 1'b1;
                  if (mem_ack && !mem_we_q) d_rdata_d = mem_rdata;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign if_done   = if_done_q;
   assign d_done    = d_done_q;
   assign err       = err_q;
   assign stall     = (if_req & ~if_done_q) | (d_req & ~d_done_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of grant order, latched payload and returned data.
module tb_mem_port_arbiter;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic [DW-1:0] if_rdata;
   logic          if_done;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic [3:0]    d_be = '0;
   logic [DW-1:0] d_rdata;
   logic          d_done;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [3:0]    mem_be;
   logic          mem_ack = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic          err;
   logic          stall;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: who was granted last, and what each requester should see.
   bit            last_data = 1'b0;
   logic [DW-1:0] m_if_rdata = '0;
   logic [DW-1:0] m_d_rdata = '0;
   logic [DW-1:0] m_wdata = '0;

   mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_rdata(d_rdata), .d_done(d_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .err(err), .stall(stall)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_stall(input logic ed_if, input logic ed_d);
      chk1("stall", stall, (if_req & ~ed_if) | (d_req & ~ed_d));
   endtask

   task automatic model_reset();
      last_data  = 1'b0;
      m_if_rdata = '0;
      m_d_rdata  = '0;
      m_wdata    = '0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk1({tag, "_mem_req"}, mem_req, 1'b0);
      chk1({tag, "_mem_we"}, mem_we, 1'b0);
      chkw({tag, "_mem_addr"}, mem_addr, '0);
      chkw({tag, "_mem_wdata"}, mem_wdata, '0);
      chk4({tag, "_mem_be"}, mem_be, 4'h0);
      chk1({tag, "_if_done"}, if_done, 1'b0);
      chk1({tag, "_d_done"}, d_done, 1'b0);
      chk1({tag, "_err"}, err, 1'b0);
      chkw({tag, "_if_rdata"}, if_rdata, '0);
      chkw({tag, "_d_rdata"}, d_rdata, '0);
   endtask

   // One idle cycle with nothing new granted.
   task automatic step_idle();
      @(negedge clk);
      chk1("idle_mem_req", mem_req, 1'b0);
      chk1("idle_if_done", if_done, 1'b0);
      chk1("idle_d_done", d_done, 1'b0);
      chk1("idle_err", err, 1'b0);
      chkw("idle_if_rdata", if_rdata, m_if_rdata);
      chkw("idle_d_rdata", d_rdata, m_d_rdata);
      chk_stall(1'b0, 1'b0);
   endtask

   // Called at the negedge where requests for the coming IDLE edge are already set.
   // wait_n >= TO means the memory never acknowledges.
   task automatic access(input int wait_n, input logic [DW-1:0] rd, output bit g_data);
      logic          ewe;
      logic [AW-1:0] eaddr;
      logic [DW-1:0] ewd;
      logic [3:0]    ebe;
      bit            abort;
      g_data = d_req && (!if_req || !last_data);
      if (g_data) begin
         ewe = d_we; eaddr = d_addr; ewd = d_wdata; ebe = d_be;
         m_wdata = d_wdata;
      end else begin
         ewe = 1'b0; eaddr = if_addr; ewd = m_wdata; ebe = 4'hF;
      end
      last_data = g_data;
      abort = (wait_n >= TO);
      for (int i = 0; i < TO; i++) begin
         @(negedge clk);
         chk1("acc_mem_req", mem_req, 1'b1);
         chk1("acc_mem_we", mem_we, ewe);
         chkw("acc_mem_addr", mem_addr, eaddr);
         chkw("acc_mem_wdata", mem_wdata, ewd);
         chk4("acc_mem_be", mem_be, ebe);
         chk1("acc_if_done", if_done, 1'b0);
         chk1("acc_d_done", d_done, 1'b0);
         chk1("acc_err", err, 1'b0);
         chk_stall(1'b0, 1'b0);
         mem_ack   = (i == wait_n);
         mem_rdata = (i == wait_n) ? rd : DW'($urandom);
         // The granted requester's payload moves; the latched copy must not.
         if (g_data) d_addr = AW'($urandom);
         else if_addr = AW'($urandom);
         if (i == wait_n) break;
      end
      @(negedge clk);
      mem_ack = 1'b0;
      if (!abort) begin
         if (g_data) begin
            if (!ewe) m_d_rdata = rd;
         end else begin
            m_if_rdata = rd;
         end
      end
      chk1("resp_mem_req", mem_req, 1'b0);
      chk1("resp_if_done", if_done, !g_data);
      chk1("resp_d_done", d_done, g_data);
      chk1("resp_err", err, abort);
      chkw("resp_if_rdata", if_rdata, m_if_rdata);
      chkw("resp_d_rdata", d_rdata, m_d_rdata);
      chk_stall(!g_data, g_data);
      if (g_data) d_req = 1'b0;
      else if_req = 1'b0;
      step_idle();
   endtask

   initial begin
      bit g;
      // Reset state.
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      chk1("reset_stall", stall, 1'b0);
      rst = 1'b0;

      // Fetch, zero-wait memory.
      if_req = 1'b1; if_addr = 32'h0000_0010;
      access(0, 32'h0050_0093, g);

      // Store with three wait cycles; d_rdata must not move.
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
      access(3, 32'h1111_2222, g);

      // Load with a known value, then a load that times out.
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200; d_be = 4'hF;
      access(1, 32'hCAFE_F00D, g);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
      access(TO, 32'h1234_5678, g);
      // Stray ack while idle is ignored.
      mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
      step_idle();
      step_idle();
      mem_ack = 1'b0;

      // Reset two cycles into a fetch access.
      if_req = 1'b1; if_addr = 32'h0000_0400;
      @(negedge clk);
      chk1("pre_rst_mem_req1", mem_req, 1'b1);
      @(negedge clk);
      chk1("pre_rst_mem_req2", mem_req, 1'b1);
      #1 rst = 1'b1;
      #1 chk1("async_rst_mem_req", mem_req, 1'b0);
      model_reset();
      @(negedge clk);
      chk_all_zero("mid_rst");
      rst = 1'b0;
      if_addr = 32'h0000_0400;
      access(0, 32'h0BAD_CAFE, g);

      // Contention right after reset: D, F, D, F.
      rst = 1'b1;
      @(negedge clk);
      model_reset();
      chk_all_zero("rst2");
      rst = 1'b0;
      if_req = 1'b1; if_addr = 32'h0000_1000;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000; d_be = 4'hF;
      for (int k = 0; k < 4; k++) begin
         access(0, DW'($urandom), g);
         if (g) begin d_req = 1'b1; d_addr = 32'h0000_2000 + k; d_we = 1'b0; end
         else begin if_req = 1'b1; if_addr = 32'h0000_1000 + k; end
      end

      // Randomized traffic.
      for (int n = 0; n < 40; n++) begin
         if (!if_req && $urandom_range(0, 1) == 1) begin
            if_req = 1'b1; if_addr = AW'($urandom);
         end
         if (!d_req && $urandom_range(0, 1) == 1) begin
            d_req = 1'b1; d_we = 1'($urandom); d_addr = AW'($urandom);
            d_wdata = DW'($urandom); d_be = 4'($urandom);
         end
         if (!if_req && !d_req) step_idle();
         else access(int'($urandom_range(0, TO)), DW'($urandom), g);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single memory port between the instruction-fetch requester and the load/store requester. It latches each granted request and drives it onto the memory port until the memory acknowledges, then returns read data with a one-cycle done pulse. It enforces round-robin fairness and aborts stuck accesses with a timeout, and it drives the pipeline stall. It sits between the PC/fetch logic, the load/store path and the unified memory.

## Interface
Parameters:
- DATA_WIDTH, 32, data width of all data buses
- ADDR_WIDTH, 32, width of all address buses
- TIMEOUT, 255, max cycles an access waits for mem_ack before abort (≥1)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- if_req  in  1  fetch request; held with if_addr until if_done
- if_addr  in  ADDR_WIDTH  fetch address
- if_rdata  out  DATA_WIDTH  fetched word; valid while if_done=1, held until next fetch capture
- if_done  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; held with payload until d_done
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_be  in  4  store byte enables
- d_rdata  out  DATA_WIDTH  load data; valid while d_done=1, held until next data capture
- d_done  out  1  one-cycle completion pulse for data
- mem_req  out  1  memory access request (registered)
- mem_we  out  1  memory write enable (registered)
- mem_addr  out  ADDR_WIDTH  memory address (registered)
- mem_wdata  out  DATA_WIDTH  memory write data (registered)
- mem_be  out  4  memory byte enables (registered)
- mem_ack  in  1  memory completion; sampled only while mem_req=1
- mem_rdata  in  DATA_WIDTH  memory read data; valid in the mem_ack cycle
- err  out  1  one-cycle pulse, coincident with the done pulse of an aborted access
- stall  out  1  combinational: (if_req & ~if_done) | (d_req & ~d_done)

## Operation
- FSM states: IDLE, IF_ACC, D_ACC, RESP.
- IDLE arbitration:
  - Only if_req → grant fetch.
  - Only d_req → grant data.
  - Both → grant the requester not granted last. last_grant resets to fetch, so data wins the first tie.
  - Neither → stay in IDLE.
- On grant:
  - Register the payload onto mem_* and set mem_req=1.
  - Fetch: mem_we=0, mem_be=4'b1111, mem_wdata unchanged.
  - Data: mem_we=d_we, mem_be=d_be, mem_wdata=d_wdata.
  - Update last_grant, clear the timeout counter, go to IF_ACC or D_ACC.
- IF_ACC / D_ACC:
  - Hold mem_* stable.
  - On mem_ack=1: capture mem_rdata into if_rdata or d_rdata (loads and fetches only; stores leave d_rdata unchanged), clear mem_req, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT with no ack, clear mem_req, set the abort flag, go to RESP (rdata not updated).
- RESP:
  - Pulse the granted requester's done for exactly one cycle; pulse err if aborted. Go to IDLE.
  - if_req/d_req are ignored in RESP.
- Requesters must deassert req in their done cycle. A req still high in IDLE is treated as a new request.
- mem_ack while mem_req=0 is ignored.
- Payload changes by a requester while granted are ignored, because the payload is latched at grant.

## Timing
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, if_done=0, d_done=0, err=0, if_rdata=0, d_rdata=0, state=IDLE, counter=0, last_grant=fetch.
- Reset asserted mid-access: mem_req drops immediately (asynchronously); no done or err is issued for that access.
- Latency: req first seen high in IDLE at edge k → mem_req=1 from cycle k+1.
- mem_ack in cycle m → done in cycle m+1 → IDLE in cycle m+2.
- Zero-wait memory (ack in the first mem_req cycle): 3-cycle request-to-IDLE turnaround, so at most one access per 3 cycles.
- Timeout: with no ack, mem_req stays high for exactly TIMEOUT cycles; done+err follow in the next cycle.
- At most one done pulse per cycle; if_done and d_done are never high together.
- stall is combinational from req and done, with no added register delay.

## Test plan
- Fetch only, if_addr=0x0000_0010, mem_ack in the first mem_req cycle, mem_rdata=0x0050_0093 → mem_req high 1 cycle with mem_addr=0x10, mem_we=0, mem_be=4'hF; if_done pulses next cycle with if_rdata=0x0050_0093; stall low after done.
- Store, d_addr=0x100, d_wdata=0xDEAD_BEEF, d_be=4'b0011, ack after 3 wait cycles → mem_req high 4 cycles, mem_we=1, mem_be=4'b0011; d_done pulses once; d_rdata unchanged.
- Simultaneous if_req and d_req right after reset, zero-wait memory → data granted first, fetch second; continued contention alternates grants (D, F, D, F), with no requester granted twice in a row.
- TIMEOUT=4, load with mem_ack held 0 → mem_req high exactly 4 cycles; d_done and err pulse together; d_rdata keeps its previous value; a later ack while mem_req=0 is ignored.
- Reset asserted 2 cycles into a fetch access → mem_req=0 asynchronously; no if_done; after release, FSM in IDLE and the held if_req is re-granted.
- mem_ack pulsed while idle and d_addr changed mid-access → no done generated; mem_addr keeps the address latched at grant.
